trace_buffer: RTL and testbench

Instruction-trace capture unit that sits on the CPU's observation outputs (pc, ir, aluOut, selRd, selRs, selRt) and acts as their consumer. It records one entry per executed instruction into a small FIFO and drains the entries as a 16-bit word stream over a valid/ready handshake. A debug UART or the testbench reads that stream. It replaces ad-hoc waveform inspection with a checkable, in-order execution log.

---
 rtl/trace_pkg.sv | 26 ++
 rtl/trace_fifo.sv | 50 +++++
 rtl/trace_buffer.sv | 80 ++++++++
 tb/tb_trace_buffer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: record layout, beat indices and packing helpers for the trace buffer
package trace_pkg;
    localparam int REC_W = 64;
    localparam int BEAT_W = 16;
    localparam logic [1:0] BEAT_PC = 2'd0;
    localparam logic [1:0] BEAT_IR = 2'd1;
    localparam logic [1:0] BEAT_ALU = 2'd2;
    localparam logic [1:0] BEAT_SEL = 2'd3;

    function automatic logic [REC_W-1:0] pack_record(
        input logic [15:0] pc,
        input logic [15:0] ir,
        input logic [15:0] alu,
        input logic [3:0] rd,
        input logic [3:0] rs,
        input logic [3:0] rt
    );
        return {pc, ir, alu, rd, rs, rt, 4'b0};
    endfunction

    function automatic logic [BEAT_W-1:0] beat_of(input logic [REC_W-1:0] rec, input logic [1:0] beat);
        return beat == BEAT_PC  ? rec[63:48] :
               beat == BEAT_IR  ? rec[47:32] :
               beat == BEAT_ALU ? rec[31:16] : rec[15:0];
    endfunction
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: single-clock record FIFO with registered count/full/empty
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int REC_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [REC_W-1:0]         din,
    output logic [REC_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [REC_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0] count_nxt;

    // occupancy after this cycle's push/pop, so status flags land on the same edge
    always_comb begin
        count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);
        head = mem[rd_ptr];
    end

    // storage has no reset; readers only look at it while non-empty
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    // pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            full <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full <= count_nxt == (AW+1)'(DEPTH);
            empty <= count_nxt == '0;
        end
    end
endmodule

// File: rtl/trace_buffer.sv
// trace_buffer: captures one record per executed instruction and streams it as 16-bit beats
module trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [15:0]              pc,
    input  logic [15:0]              ir,
    input  logic [15:0]              aluOut,
    input  logic [3:0]               selRd,
    input  logic [3:0]               selRs,
    input  logic [3:0]               selRt,
    output logic [15:0]              outData,
    output logic                     outValid,
    input  logic                     outReady,
    output logic                     outLast,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [DROP_W-1:0]        dropped
);
    logic primed;
    logic [15:0] last_pc;
    logic [1:0] beat;
    logic capture;
    logic push;
    logic pop;
    logic [REC_W-1:0] head;

    // a full FIFO still accepts a record when the head's last beat leaves this cycle
    always_comb begin
        capture = en && (!primed || pc != last_pc);
        outValid = !empty;
        outLast = outValid && beat == BEAT_SEL;
        pop = outLast && outReady;
        push = capture && (!full || pop);
        outData = outValid ? beat_of(head, beat) : '0;
    end

    // dedup: a stalled pc is one instruction; disabling forgets the last pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed <= 1'b0;
            last_pc <= '0;
        end else if (!en) begin
            primed <= 1'b0;
        end else if (capture) begin
            primed <= 1'b1;
            last_pc <= pc;
        end
    end

    // beat index wraps 3->0 exactly when the head record is popped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) beat <= BEAT_PC;
        else if (outValid && outReady) beat <= beat + 2'd1;
    end

    // saturating count of records discarded for lack of space
    always_ff @(posedge clk or posedge rst) begin
        if (rst) dropped <= '0;
        else if (capture && !push && dropped != '1) dropped <= dropped + 1'b1;
    end

    trace_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .din(pack_record(pc, ir, aluOut, selRd, selRs, selRt)),
        .head(head),
        .count(count),
        .full(full),
        .empty(empty)
    );
endmodule

// File: tb/tb_trace_buffer.sv
// tb_trace_buffer: scoreboard bench for the instruction trace buffer
module tb_trace_buffer;
    logic clk = 1'b0;
    logic rst, en, outReady, outValid, outLast, full, empty;
    logic [15:0] pc, ir, aluOut, outData;
    logic [3:0] selRd, selRs, selRt, count;
    logic [7:0] dropped;
    int vectors = 0;
    int miscompares = 0;
    logic [16:0] exp_q [$];

    trace_buffer #(.DEPTH(8), .DROP_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .pc(pc), .ir(ir), .aluOut(aluOut),
        .selRd(selRd), .selRs(selRs), .selRt(selRt), .outData(outData),
        .outValid(outValid), .outReady(outReady), .outLast(outLast),
        .count(count), .full(full), .empty(empty), .dropped(dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    function automatic void exp_rec(input logic [15:0] p, i, a, input logic [3:0] d, s, t);
        exp_q.push_back({1'b0, p});
        exp_q.push_back({1'b0, i});
        exp_q.push_back({1'b0, a});
        exp_q.push_back({1'b1, d, s, t, 4'h0});
    endfunction

    task automatic cap(input logic [15:0] p, i, a, input logic [3:0] d, s, t);
        pc = p; ir = i; aluOut = a; selRd = d; selRs = s; selRt = t; en = 1'b1;
        @(negedge clk);
    endtask

    task automatic drain(input int n, input int budget);
        int got = 0;
        int cyc = 0;
        logic [16:0] e;
        outReady = 1'b1;
        while (got < n && cyc < budget) begin
            if (outValid) begin
                e = exp_q.size() > 0 ? exp_q.pop_front() : 17'h0;
                vectors++;
                if (outData !== e[15:0] || outLast !== e[16]) begin
                    miscompares++;
                    $display("FAIL drain beat %0d: got data=%h last=%b want data=%h last=%b", got, outData, outLast, e[15:0], e[16]);
                end
                got++;
            end
            cyc++;
            @(negedge clk);
        end
        outReady = 1'b0;
        vectors++;
        if (got != n) begin
            miscompares++;
            $display("FAIL drain_count: got %0d beats want %0d within %0d cycles", got, n, budget);
        end
    endtask

    task automatic test_reset();
        vectors += 7;
        if (count !== 4'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", empty); end
        if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", full); end
        if (outValid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", outValid); end
        if (outLast !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", outLast); end
        if (outData !== 16'h0) begin miscompares++; $display("FAIL reset_data: got %h want 0000", outData); end
        if (dropped !== 8'd0) begin miscompares++; $display("FAIL reset_dropped: got %0d want 0", dropped); end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) cap(16'h0100 + 16'(2 * k), 16'h0, 16'h0, 4'h0, 4'h0, 4'h0);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 4'd3) begin miscompares++; $display("FAIL pre_reset_count: got %0d want 3", count); end
        outReady = 1'b1;
        @(negedge clk);
        outReady = 1'b0;
        #2 rst = 1'b1;
        #1;
        vectors += 4;
        if (count !== 4'd0) begin miscompares++; $display("FAIL midrst_count: got %0d want 0", count); end
        if (empty !== 1'b1) begin miscompares++; $display("FAIL midrst_empty: got %b want 1", empty); end
        if (outValid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", outValid); end
        if (dropped !== 8'd0) begin miscompares++; $display("FAIL midrst_dropped: got %0d want 0", dropped); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        exp_rec(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0);
        exp_rec(16'h0002, 16'h1234, 16'h0005, 4'd1, 4'd2, 4'd3);
        fork
            begin
                cap(16'h0000, 16'h0000, 16'h0000, 4'd0, 4'd0, 4'd0);
                cap(16'h0002, 16'h1234, 16'h0005, 4'd1, 4'd2, 4'd3);
                en = 1'b0;
            end
            drain(8, 40);
        join
    endtask

    task automatic test_dedup();
        repeat (5) cap(16'h0010, 16'h00AA, 16'h00BB, 4'd4, 4'd5, 4'd6);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 4'd1) begin miscompares++; $display("FAIL dedup_hold: got count %0d want 1", count); end
        cap(16'h0010, 16'h00AA, 16'h00BB, 4'd4, 4'd5, 4'd6);
        en = 1'b0;
        @(negedge clk);
        vectors++;
        if (count !== 4'd2) begin miscompares++; $display("FAIL dedup_reenable: got count %0d want 2", count); end
        exp_rec(16'h0010, 16'h00AA, 16'h00BB, 4'd4, 4'd5, 4'd6);
        exp_rec(16'h0010, 16'h00AA, 16'h00BB, 4'd4, 4'd5, 4'd6);
        drain(8, 40);
    endtask

    task automatic test_backpressure();
        cap(16'h0020, 16'hC0DE, 16'hBEEF, 4'd7, 4'd8, 4'd9);
        en = 1'b0;
        exp_rec(16'h0020, 16'hC0DE, 16'hBEEF, 4'd7, 4'd8, 4'd9);
        repeat (10) begin
            @(negedge clk);
            vectors++;
            if (outValid !== 1'b1 || outData !== 16'h0020 || outLast !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%b data=%h last=%b want 1 0020 0", outValid, outData, outLast);
            end
        end
        drain(4, 4);
        vectors++;
        if (empty !== 1'b1) begin miscompares++; $display("FAIL stall_empty_after: got %b want 1", empty); end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 11; k++) begin
            cap(16'h0040 + 16'(2 * k), 16'h0100 + 16'(k), 16'h0200 + 16'(k), 4'(k), 4'(k + 1), 4'(k + 2));
            if (k < 8) exp_rec(16'h0040 + 16'(2 * k), 16'h0100 + 16'(k), 16'h0200 + 16'(k), 4'(k), 4'(k + 1), 4'(k + 2));
        end
        en = 1'b0;
        @(negedge clk);
        vectors += 3;
        if (count !== 4'd8) begin miscompares++; $display("FAIL ovf_count: got %0d want 8", count); end
        if (full !== 1'b1) begin miscompares++; $display("FAIL ovf_full: got %b want 1", full); end
        if (dropped !== 8'd3) begin miscompares++; $display("FAIL ovf_dropped: got %0d want 3", dropped); end
    endtask

    task automatic test_full_pop();
        logic [16:0] e;
        outReady = 1'b1;
        for (int b = 0; b < 4; b++) begin
            e = exp_q.pop_front();
            vectors++;
            if (outData !== e[15:0] || outLast !== e[16]) begin
                miscompares++;
                $display("FAIL fullpop_beat%0d: got data=%h last=%b want data=%h last=%b", b, outData, outLast, e[15:0], e[16]);
            end
            if (b == 3) begin
                pc = 16'h0500; ir = 16'h5555; aluOut = 16'h6666;
                selRd = 4'd10; selRs = 4'd11; selRt = 4'd12; en = 1'b1;
            end
            @(negedge clk);
        end
        outReady = 1'b0;
        en = 1'b0;
        exp_rec(16'h0500, 16'h5555, 16'h6666, 4'd10, 4'd11, 4'd12);
        vectors += 3;
        if (count !== 4'd8) begin miscompares++; $display("FAIL fullpop_count: got %0d want 8", count); end
        if (full !== 1'b1) begin miscompares++; $display("FAIL fullpop_full: got %b want 1", full); end
        if (dropped !== 8'd3) begin miscompares++; $display("FAIL fullpop_dropped: got %0d want 3", dropped); end
        @(negedge clk);
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 260; k++) cap(16'h1000 + 16'(k), 16'h0, 16'h0, 4'd0, 4'd0, 4'd0);
        en = 1'b0;
        @(negedge clk);
        vectors += 2;
        if (dropped !== 8'd255) begin miscompares++; $display("FAIL sat_dropped: got %0d want 255", dropped); end
        if (count !== 4'd8) begin miscompares++; $display("FAIL sat_count: got %0d want 8", count); end
        drain(32, 200);
        vectors++;
        if (empty !== 1'b1) begin miscompares++; $display("FAIL sat_drain_empty: got %b want 1", empty); end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; outReady = 1'b0;
        pc = '0; ir = '0; aluOut = '0; selRd = '0; selRs = '0; selRt = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_basic();
        test_dedup();
        test_backpressure();
        test_overflow();
        test_full_pop();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
